// File: rtl/cntr_sched_pkg.sv
// Shared constants and types for the counter-cycle scheduler.
// Default cell count, chain mask, direction encoding and the FSM state type.
package cntr_sched_pkg;

   localparam int NCELL_DEF = 20;
   localparam int IDX_W     = $clog2(NCELL_DEF);

   localparam logic DIR_PINC = 1'b0;
   localparam logic DIR_MINC = 1'b1;

   // Only TIME1 (cell 1) carries into TIME2 (cell 0) by default.
   localparam logic [NCELL_DEF-1:0] CHAIN_DEF = NCELL_DEF'(2);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

endpackage

// File: rtl/cntr_prio_enc.sv
// Lowest-index-first priority encoder.
// Index 0 has the highest priority.
module cntr_prio_enc #(
   parameter int N  = 20,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   output logic          valid,
   output logic [IW-1:0] idx
);

   // Scan downward so that the last hit, and therefore the lowest index, wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = IW'(i);
         end
      end
   end

endmodule

// File: rtl/cntr_sched.sv
// Counter-cycle scheduler: latches PINC/MINC requests, grants one cell per MCT
// at each T12 rising edge and forwards overflow/underflow carries along the chain.
module cntr_sched
   import cntr_sched_pkg::*;
#(
   parameter int               NCELL = NCELL_DEF,
   parameter logic [NCELL-1:0] CHAIN = NCELL'(CHAIN_DEF),
   parameter int               IW    = $clog2(NCELL)
) (
   input  logic             SIM_CLK,
   input  logic             SIM_RST,
   input  logic             GOJAM,
   input  logic             T12,
   input  logic             CNT_INH,
   input  logic [NCELL-1:0] PINC_REQ,
   input  logic [NCELL-1:0] MINC_REQ,
   input  logic             OVF_n,
   input  logic             UNF_n,
   output logic             CNT_ACT,
   output logic [IW-1:0]    CNT_IDX,
   output logic             CNT_DIR,
   output logic             CNT_PEND,
   output logic             OVRUN
);

   state_e           state_q;
   logic             t12_q;
   logic [NCELL-1:0] p_q, m_q;
   logic             carry_q;
   logic [IW-1:0]    idx_q;
   logic             dir_q;
   logic             ovr_q;

   logic             dec;
   logic             act;
   logic             sample;
   logic             mrg_en;
   logic             mrg_ovr;
   logic             req_ovr;
   logic [IW-1:0]    tgt;
   logic [NCELL-1:0] p_mrg, m_mrg;
   logic [NCELL-1:0] p_d, m_d;
   logic             enc_vld;
   logic [IW-1:0]    enc_idx;
   logic             grant;

   assign act    = (state_q == ST_ACTIVE);
   assign dec    = T12 & ~t12_q;
   assign sample = act & ((dir_q == DIR_MINC) ? ~UNF_n : ~OVF_n);
   assign tgt    = idx_q - IW'(1);
   assign mrg_en = dec & act & (carry_q | sample) & (idx_q != '0) & CHAIN[idx_q];

   // Carry from the finishing cycle enters the pending set before arbitration.
   always_comb begin
      p_mrg   = p_q;
      m_mrg   = m_q;
      mrg_ovr = 1'b0;
      if (mrg_en) begin
         if (dir_q == DIR_PINC) begin
            if (p_q[tgt])      mrg_ovr    = 1'b1;
            else if (m_q[tgt]) m_mrg[tgt] = 1'b0;
            else               p_mrg[tgt] = 1'b1;
         end else begin
            if (m_q[tgt])      mrg_ovr    = 1'b1;
            else if (p_q[tgt]) p_mrg[tgt] = 1'b0;
            else               m_mrg[tgt] = 1'b1;
         end
      end
   end

   cntr_prio_enc #(
      .N  (NCELL),
      .IW (IW)
   ) u_enc (
      .req   (p_mrg | m_mrg),
      .valid (enc_vld),
      .idx   (enc_idx)
   );

   assign grant = dec & enc_vld & ~CNT_INH;

   // New requests are applied after the grant, so a decision-clock request waits a round.
   always_comb begin
      p_d     = p_mrg;
      m_d     = m_mrg;
      req_ovr = 1'b0;
      if (grant) begin
         if (p_mrg[enc_idx]) p_d[enc_idx] = 1'b0;
         else                m_d[enc_idx] = 1'b0;
      end
      for (int i = 0; i < NCELL; i++) begin
         if (PINC_REQ[i] & ~MINC_REQ[i]) begin
            if (p_d[i])      req_ovr = 1'b1;
            else if (m_d[i]) m_d[i]  = 1'b0;
            else             p_d[i]  = 1'b1;
         end else if (MINC_REQ[i] & ~PINC_REQ[i]) begin
            if (m_d[i])      req_ovr = 1'b1;
            else if (p_d[i]) p_d[i]  = 1'b0;
            else             m_d[i]  = 1'b1;
         end
      end
   end

   always_ff @(posedge SIM_CLK) begin
      if (!SIM_RST) begin
         state_q <= ST_IDLE;
         t12_q   <= 1'b0;
         p_q     <= '0;
         m_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         dir_q   <= DIR_PINC;
         ovr_q   <= 1'b0;
      end else begin
         t12_q <= T12;
         if (GOJAM) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            m_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            dir_q   <= DIR_PINC;
         end else begin
            p_q <= p_d;
            m_q <= m_d;
            if (mrg_ovr | req_ovr) ovr_q <= 1'b1;
            if (dec) begin
               carry_q <= 1'b0;
               if (grant) begin
                  state_q <= ST_ACTIVE;
                  idx_q   <= enc_idx;
                  dir_q   <= p_mrg[enc_idx] ? DIR_PINC : DIR_MINC;
               end else begin
                  state_q <= ST_IDLE;
               end
            end else begin
               carry_q <= carry_q | sample;
            end
         end
      end
   end

   assign CNT_ACT  = act;
   assign CNT_IDX  = idx_q;
   assign CNT_DIR  = dir_q;
   assign CNT_PEND = |(p_q | m_q);
   assign OVRUN    = ovr_q;

endmodule

// File: tb/tb_cntr_sched.sv
// Bench for cntr_sched: directed vector table, chain-carry sequences and
// randomized traffic compared against a net-count reference model.
module tb_cntr_sched;
   import cntr_sched_pkg::*;

   localparam int N  = NCELL_DEF;
   localparam int IW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0, gj = 1'b0, t12 = 1'b0, inh = 1'b0;
   logic          ovf_n = 1'b1, unf_n = 1'b1;
   logic [N-1:0]  pinc = '0, minc = '0;
   logic          act, dir, pend, ovr;
   logic [IW-1:0] idx;
   logic          act_nc, dir_nc, pend_nc, ovr_nc;
   logic [IW-1:0] idx_nc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cntr_sched dut (
      .SIM_CLK(clk), .SIM_RST(rst_n), .GOJAM(gj), .T12(t12), .CNT_INH(inh),
      .PINC_REQ(pinc), .MINC_REQ(minc), .OVF_n(ovf_n), .UNF_n(unf_n),
      .CNT_ACT(act), .CNT_IDX(idx), .CNT_DIR(dir), .CNT_PEND(pend), .OVRUN(ovr)
   );

   cntr_sched #(.CHAIN('0)) dut_nc (
      .SIM_CLK(clk), .SIM_RST(rst_n), .GOJAM(gj), .T12(t12), .CNT_INH(inh),
      .PINC_REQ(pinc), .MINC_REQ(minc), .OVF_n(ovf_n), .UNF_n(unf_n),
      .CNT_ACT(act_nc), .CNT_IDX(idx_nc), .CNT_DIR(dir_nc), .CNT_PEND(pend_nc), .OVRUN(ovr_nc)
   );

   typedef struct {
      bit r, g, t, i;
      int pi, mi;
      bit e_act;
      int e_idx;
      bit e_dir, e_pend, e_ovr, chk_id;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input bit r, g, t, i, input int pi, mi,
                              input bit a, input int x, input bit d, p, o, c);
      vec_t e;
      e.r = r; e.g = g; e.t = t; e.i = i; e.pi = pi; e.mi = mi;
      e.e_act = a; e.e_idx = x; e.e_dir = d; e.e_pend = p; e.e_ovr = o; e.chk_id = c;
      return e;
   endfunction

   function automatic logic [N-1:0] oh(input int k);
      logic [N-1:0] m;
      m = '0;
      if (k >= 0) m[k] = 1'b1;
      return m;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step(input bit r, g, t, i, o, u, input logic [N-1:0] pv, mv);
      @(negedge clk);
      rst_n = r; gj = g; t12 = t; inh = i; ovf_n = o; unf_n = u; pinc = pv; minc = mv;
      @(posedge clk);
      #1;
   endtask

   task automatic st(input bit t, input int pi, mi, input bit o, u);
      step(1'b1, 1'b0, t, 1'b0, o, u, oh(pi), oh(mi));
   endtask

   task automatic hs(input string name, input bit a, input int x, input bit d);
      chk({name, ".act"}, act, a);
      if (a) begin
         chk({name, ".idx"}, idx, x);
         chk({name, ".dir"}, dir, d);
      end
   endtask

   // Reference model: each cell holds a net pending count in {-1,0,+1}.
   int mp[N];
   bit m_act, m_dir, m_carry, m_ovr, m_t12;
   int m_idx;

   task automatic m_add(input int c, input int d);
      if (mp[c] + d > 1 || mp[c] + d < -1) m_ovr = 1'b1;
      else mp[c] = mp[c] + d;
   endtask

   task automatic model_step(input bit r, g, t, i, o, u, input logic [N-1:0] pv, mv);
      bit smp;
      int sel;
      if (!r) begin
         foreach (mp[c]) mp[c] = 0;
         m_act = 0; m_idx = 0; m_dir = 0; m_carry = 0; m_ovr = 0; m_t12 = 0;
         return;
      end
      if (g) begin
         foreach (mp[c]) mp[c] = 0;
         m_act = 0; m_idx = 0; m_dir = 0; m_carry = 0; m_t12 = t;
         return;
      end
      smp = m_act && (m_dir ? !u : !o);
      if (t && !m_t12) begin
         if (m_act && (m_carry || smp) && m_idx > 0 && CHAIN_DEF[m_idx])
            m_add(m_idx - 1, m_dir ? -1 : 1);
         sel = -1;
         for (int c = 0; c < N; c++) if (sel < 0 && mp[c] != 0) sel = c;
         if (sel >= 0 && !i) begin
            m_act = 1; m_idx = sel; m_dir = (mp[sel] < 0); mp[sel] = 0;
         end else begin
            m_act = 0;
         end
         m_carry = 0;
      end else if (smp) begin
         m_carry = 1;
      end
      for (int c = 0; c < N; c++) m_add(c, int'(pv[c]) - int'(mv[c]));
      m_t12 = t;
   endtask

   initial begin
      bit r, g, t, i, o, u, tv, anyp;
      logic [N-1:0] pv, mv;
      int tcnt;

      //               r g t i  pi  mi   a x d p o c
      tbl.push_back(v(0,0,0,0, -1, -1,  0,0,0,0,0,1));
      tbl.push_back(v(1,0,0,0,  5, -1,  0,0,0,1,0,0));
      tbl.push_back(v(1,0,0,0, -1, -1,  0,0,0,1,0,0));
      tbl.push_back(v(1,0,1,0, -1, -1,  1,5,0,0,0,0));
      tbl.push_back(v(1,0,1,0, -1, -1,  1,5,0,0,0,0));
      tbl.push_back(v(1,0,0,0, -1, -1,  1,5,0,0,0,0));
      tbl.push_back(v(1,0,0,0,  7, -1,  1,5,0,1,0,0));
      tbl.push_back(v(1,0,0,0, -1,  3,  1,5,0,1,0,0));
      tbl.push_back(v(1,0,1,0, -1, -1,  1,3,1,1,0,0));
      tbl.push_back(v(1,0,0,0, -1, -1,  1,3,1,1,0,0));
      tbl.push_back(v(1,0,1,0, -1, -1,  1,7,0,0,0,0));
      tbl.push_back(v(1,0,0,0, -1, -1,  1,7,0,0,0,0));
      tbl.push_back(v(1,0,1,0, -1, -1,  0,0,0,0,0,0));
      tbl.push_back(v(1,0,0,0,  4, -1,  0,0,0,1,0,0));
      tbl.push_back(v(1,0,0,0, -1,  4,  0,0,0,0,0,0));
      tbl.push_back(v(1,0,1,0, -1, -1,  0,0,0,0,0,0));
      tbl.push_back(v(1,0,0,0,  4,  4,  0,0,0,0,0,0));
      tbl.push_back(v(1,0,0,0,  4, -1,  0,0,0,1,0,0));
      tbl.push_back(v(1,0,0,0,  4, -1,  0,0,0,1,1,0));
      tbl.push_back(v(1,0,1,0, -1, -1,  1,4,0,0,1,0));
      tbl.push_back(v(1,1,0,0,  6, -1,  0,0,0,0,1,1));
      tbl.push_back(v(1,0,0,0, -1, -1,  0,0,0,0,1,0));
      tbl.push_back(v(1,0,0,0, -1,  9,  0,0,0,1,1,0));
      tbl.push_back(v(1,0,1,1, -1, -1,  0,0,0,1,1,0));
      tbl.push_back(v(1,0,0,0, -1, -1,  0,0,0,1,1,0));
      tbl.push_back(v(1,0,1,0, -1, -1,  1,9,1,0,1,0));
      tbl.push_back(v(1,0,0,0, -1, -1,  1,9,1,0,1,0));
      tbl.push_back(v(1,0,1,0,  2, -1,  0,0,0,1,1,0));
      tbl.push_back(v(1,0,0,0, -1, -1,  0,0,0,1,1,0));
      tbl.push_back(v(1,0,1,0, -1, -1,  1,2,0,0,1,0));
      tbl.push_back(v(0,0,0,0, -1, -1,  0,0,0,0,0,1));
      tbl.push_back(v(1,0,0,0, -1, -1,  0,0,0,0,0,0));

      foreach (tbl[k]) begin
         step(tbl[k].r, tbl[k].g, tbl[k].t, tbl[k].i, 1'b1, 1'b1, oh(tbl[k].pi), oh(tbl[k].mi));
         chk($sformatf("v%0d.act", k), act, tbl[k].e_act);
         chk($sformatf("v%0d.pend", k), pend, tbl[k].e_pend);
         chk($sformatf("v%0d.ovrun", k), ovr, tbl[k].e_ovr);
         if (tbl[k].e_act || tbl[k].chk_id) begin
            chk($sformatf("v%0d.idx", k), idx, tbl[k].e_idx);
            chk($sformatf("v%0d.dir", k), dir, tbl[k].e_dir);
         end
      end

      // OVF during a cell-1 PINC cycle chains into cell 0, only where CHAIN[1] is set.
      st(0, 1, -1, 1, 1);
      st(1, -1, -1, 1, 1);
      hs("chain.g1", 1, 1, 0);
      chk("chain_nc.g1.act", act_nc, 1);
      chk("chain_nc.g1.idx", idx_nc, 1);
      chk("chain_nc.g1.dir", dir_nc, 0);
      st(0, -1, -1, 1, 1);
      st(0, -1, -1, 0, 1);
      st(0, -1, -1, 1, 1);
      st(1, -1, -1, 1, 1);
      hs("chain.g0", 1, 0, 0);
      chk("chain.pend", pend, 0);
      chk("chain_nc.act", act_nc, 0);
      chk("chain_nc.pend", pend_nc, 0);
      st(0, -1, -1, 1, 1);
      st(1, -1, -1, 1, 1);
      hs("chain.end", 0, 0, 0);

      // UNF during a PINC cycle is not a carry.
      st(0, 1, -1, 1, 1);
      st(1, -1, -1, 1, 1);
      hs("unfp.g1", 1, 1, 0);
      st(0, -1, -1, 1, 1);
      st(0, -1, -1, 1, 0);
      st(0, -1, -1, 1, 1);
      st(1, -1, -1, 1, 1);
      hs("unfp.next", 0, 0, 0);
      chk("unfp.pend", pend, 0);

      // UNF during a MINC cycle chains a MINC.
      st(0, -1, 1, 1, 1);
      st(1, -1, -1, 1, 1);
      hs("unfm.g1", 1, 1, 1);
      st(0, -1, -1, 1, 1);
      st(0, -1, -1, 1, 0);
      st(0, -1, -1, 1, 1);
      st(1, -1, -1, 1, 1);
      hs("unfm.g0", 1, 0, 1);
      chk("nc.ovrun", ovr_nc, 0);

      // Randomized traffic against the reference model.
      tv = 0;
      tcnt = 0;
      for (int k = 0; k < 3000; k++) begin
         r = (k == 0) ? 1'b0 : ($urandom_range(0, 499) != 0);
         g = ($urandom_range(0, 299) == 0);
         if (tcnt == 0) begin
            tv = ~tv;
            tcnt = $urandom_range(1, 4);
         end
         tcnt--;
         t = tv;
         i = ($urandom_range(0, 7) == 0);
         o = ($urandom_range(0, 5) != 0);
         u = ($urandom_range(0, 5) != 0);
         pv = '0;
         mv = '0;
         if ($urandom_range(0, 2) == 0)
            pv[$urandom_range(0, 1) != 0 ? $urandom_range(0, 3) : $urandom_range(0, N - 1)] = 1'b1;
         if ($urandom_range(0, 3) == 0)
            mv[$urandom_range(0, 1) != 0 ? $urandom_range(0, 3) : $urandom_range(0, N - 1)] = 1'b1;
         model_step(r, g, t, i, o, u, pv, mv);
         step(r, g, t, i, o, u, pv, mv);
         anyp = 0;
         foreach (mp[c]) if (mp[c] != 0) anyp = 1;
         chk($sformatf("rnd%0d.act", k), act, m_act);
         chk($sformatf("rnd%0d.pend", k), pend, anyp);
         chk($sformatf("rnd%0d.ovrun", k), ovr, m_ovr);
         if (m_act) begin
            chk($sformatf("rnd%0d.idx", k), idx, m_idx);
            chk($sformatf("rnd%0d.dir", k), dir, m_dir);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cntr_sched.md
# cntr_sched

Counter-cycle scheduler that shares the timer-driven memory cycle (MCT) between involuntary counter requesters. It latches single-clock PINC/MINC requests from up to NCELL counter cells, and at each T12 boundary grants at most one cell a counter cycle for the following MCT, using fixed priority where the lowest index wins. It also propagates overflow and underflow carries between chained cells, for example TIME1 into TIME2. It sits beside the timer, consuming T12, GOJAM, OVF_n and UNF_n, and drives the counter-increment sequencing in the control logic.

## Interface
- NCELL, 20: number of counter cells; index 0 has the highest priority.
- CHAIN, NCELL'b0 with bit 1 set: bit i set means a carry out of cell i requests cell i-1; bit 0 is ignored.
- SIM_CLK  in  1  system clock; all state changes on its rising edge.
- SIM_RST  in  1  reset, synchronous, active-low.
- GOJAM  in  1  restart; synchronously clears pending requests and any active grant.
- T12  in  1  timer timepulse, level over several SIM_CLK; its rising edge is the decision point.
- CNT_INH  in  1  when high at a decision point, no new grant is issued.
- PINC_REQ  in  NCELL  plus-increment request pulses, one SIM_CLK each.
- MINC_REQ  in  NCELL  minus-increment request pulses.
- OVF_n, UNF_n  in  1  overflow and underflow strobes from the timer, active-low.
- CNT_ACT  out  1  a counter cycle is granted for the current MCT.
- CNT_IDX  out  $clog2(NCELL)  index of the granted cell.
- CNT_DIR  out  1  0 = PINC, 1 = MINC.
- CNT_PEND  out  1  OR of all pending flags.
- OVRUN  out  1  sticky flag: a request was dropped.

## Operation
- Per cell there are two pending flags, P[i] and M[i].
- Latch rules, applied each SIM_CLK:
  - A request with the same-direction flag already set is dropped and sets OVRUN.
  - A request with the opposite flag set clears that flag. Net zero, no grant.
  - PINC and MINC in the same clock for the same cell cancel. No flag change.
- Two states: IDLE and ACTIVE.
- At a decision point (T12 rising edge, detected against a registered T12):
  - If ACTIVE and CHAIN[CNT_IDX] is set, the carry sampled during the cycle is merged into cell CNT_IDX-1 using the latch rules above. An OVF during PINC produces a PINC; a UNF during MINC produces a MINC.
  - Arbitration then runs over the pending set. That set includes the merged carry but excludes requests arriving on the decision clock itself.
  - Arbitration selects the lowest i with P[i] or M[i] set. If both are set, P wins; this cannot happen under the latch rules but must be deterministic.
  - If a cell is selected and CNT_INH is low, the block enters or stays in ACTIVE, loads CNT_IDX and CNT_DIR, and clears the granted flag. Otherwise it enters IDLE.
- Carry sampling: while ACTIVE, a sticky register captures OVF_n==0 (PINC) or UNF_n==0 (MINC). The register clears at every decision point.
- GOJAM has priority over everything except reset:
  - All flags and the carry register clear, state becomes IDLE, and CNT_ACT goes to 0 on the next edge.
  - Requests arriving with GOJAM are discarded.
  - OVRUN is not cleared by GOJAM.

## Timing
- Reset values: CNT_ACT=0, CNT_IDX=0, CNT_DIR=0, CNT_PEND=0, OVRUN=0. All flags clear, IDLE, registered T12=0.
- A request pulse at clock k is visible on CNT_PEND at k+1.
- A decision at clock d (T12 low at d-1, high at d) gives CNT_ACT, CNT_IDX and CNT_DIR valid from d+1 until the next decision.
- Back-to-back grants are allowed. CNT_ACT stays high across the boundary when the next cell is granted immediately.
- A carry from a cycle ending at decision d is eligible at d itself. With default CHAIN, the TIME1 to TIME2 carry is therefore granted in the very next MCT unless a lower index is pending.
- T12 held high produces no further decisions. Only rising edges count.
- If reset is asserted mid-cycle, all outputs return to reset values on the next edge.

## Structure
- Package cntr_sched_pkg:
  - NCELL default.
  - IDX_W = $clog2(NCELL).
  - Direction constants DIR_PINC=0 and DIR_MINC=1.
  - Default CHAIN mask.
- Sub-module cntr_prio_enc: a combinational lowest-index-first encoder with inputs req[NCELL] and outputs valid and idx. It is instantiated once, on the OR of P and M.

## Test plan
- **Single request.** PINC_REQ[5] pulse, then T12 rise at d -> CNT_ACT=1, CNT_IDX=5, CNT_DIR=0 from d+1; CNT_PEND=0 from d+1.
- **Priority.** PINC[7] and MINC[3] both pending -> grant 3/MINC at the first decision, 7/PINC at the second, CNT_ACT=0 after the third.
- **Cancel and overrun.**
  - PINC[4] then MINC[4] -> no grant.
  - PINC[4] twice before a decision -> one grant, OVRUN=1 and it stays 1 through GOJAM.
- **Chain carry.** Grant cell 1 PINC, OVF_n low for 1 clock during the cycle -> next decision grants cell 0 PINC.
- **Carry gating.** The same carry with CHAIN[1]=0 -> no grant. UNF_n low during a PINC cycle -> no carry.
- **Inhibit, decision-clock request, reset and GOJAM.**
  - CNT_INH=1 at a decision -> CNT_ACT=0, flags retained, granted at the next decision.
  - A request on the decision clock is granted only at the following decision.
  - GOJAM or SIM_RST=0 mid-ACTIVE -> all outputs return to reset values on the next clock.
